uart_rx_clic: RTL and testbench
===============================

# uart_rx_clic

Serial UART receiver peripheral for the Hippomenes core: 8N1 framing, LSB first, one-byte holding register, sticky overrun/framing flags and a single-cycle interrupt request into the N-CLIC. It is the receive-side counterpart of the core's serial output path. It sits beside the CSR/peripheral logic of `top_n_clic`. Its `rx_irq` drives one CLIC interrupt line, and the core reads `rx_data` in that handler.

## Interface
Parameters:
- `ClkFreq`, 20_000_000, core clock in Hz.
- `BaudRate`, 115_200, line rate in baud.
- Derived: `ClksPerBit = ClkFreq / BaudRate`, integer truncation; must be ≥ 4. `HalfBit = ClksPerBit / 2`.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk`; 0 = reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `rd_ack`  in  1  core has consumed `rx_data`; clears `rx_valid`.
- `clr_err`  in  1  clears `overrun` and `frame_err`.
- `rx_data`  out  8  last good byte received.
- `rx_valid`  out  1  holding register contains an unread byte.
- `rx_irq`  out  1  one-cycle pulse per good byte; goes to the CLIC.
- `overrun`  out  1  sticky: a byte arrived while `rx_valid=1` and no `rd_ack` was present.
- `frame_err`  out  1  sticky: a stop bit was sampled low.

## Operation
- Synchronizer: two flops on `rx`. Both reset to 1. The FSM sees only `rx_s`, the second flop's output.
- Counters:
  - Bit-timing counter `cnt`, ⌈log2 ClksPerBit⌉ bits.
  - Bit index `idx`, 3 bits.
  - Shift register `sh`, 8 bits; bits enter at the MSB and shift right, so the LSB arrives first.
- FSM states:
  - IDLE: `cnt=0`. When `rx_s=0`, go to START.
  - START: `cnt` counts up to `HalfBit-1`. At `HalfBit-1`:
    - `rx_s=1`: glitch; return to IDLE with no flag change.
    - `rx_s=0`: clear `cnt` and `idx`, go to DATA.
  - DATA: `cnt` counts up to `ClksPerBit-1`. At `ClksPerBit-1`, shift `rx_s` into `sh` and clear `cnt`. When `idx=7`, go to STOP; otherwise increment `idx`.
  - STOP: at `cnt=ClksPerBit-1`, sample `rx_s`:
    - `rx_s=1`: load `rx_data<=sh`, set `rx_valid<=1`, pulse `rx_irq` for one cycle.
    - `rx_s=0`: set `frame_err<=1`. `rx_data`, `rx_valid` and `rx_irq` are untouched.
    - In both cases, go to IDLE on the next cycle. Because the stop bit is sampled mid-bit, a back-to-back start bit is caught.
- Holding register rules, evaluated in the cycle a good stop bit is sampled:
  - `rx_valid=0`: load; no overrun.
  - `rx_valid=1` and `rd_ack=1`: load; `rx_valid` stays 1; no overrun.
  - `rx_valid=1` and `rd_ack=0`: load (overwrite with the new byte); set `overrun<=1`.
- `rd_ack` without a new byte: `rx_valid<=0` next cycle. `rx_data` holds its value.
- `clr_err` and a new error in the same cycle: the error wins, and the flag stays 1.
- `rx_irq` is never asserted on a framing error or a glitch.

## Timing
- Reset, checked on the first rising edge with `reset=0`:
  - `rx_data=8'h00`; `rx_valid`, `rx_irq`, `overrun`, `frame_err` = 0.
  - FSM in IDLE; synchronizer flops = 1.
  - This holds even if reset is asserted mid-frame. The frame in progress is dropped, with no flag and no irq.
- Start detection: the falling edge on `rx` appears on `rx_s` 2 cycles later. The start-bit check lands `HalfBit` cycles after that.
- Data bit k (0..7) is sampled `HalfBit + (k+1)·ClksPerBit` cycles after `rx_s` falls, i.e. at mid-bit.
- The stop bit is sampled `HalfBit + 9·ClksPerBit` cycles after `rx_s` falls. `rx_valid`, `rx_data` and `rx_irq` update on that same edge, so they are visible the next cycle.
- `rx_irq` is high for exactly 1 cycle and is registered, with no combinational path from `rx`.
- `rd_ack` → `rx_valid` low: 1 cycle.
- The baud rate is fixed at elaboration. There is no run-time divisor.

## Test plan
Use `ClkFreq=1600` and `BaudRate=100`, giving `ClksPerBit=16` and `HalfBit=8`. All scenarios run after a reset release.

- Hold `reset=0` for 3 cycles with `rx=1` → all outputs 0; then idle for 200 cycles → no `rx_irq`.
- Send frame `0x A5` (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) → exactly one `rx_irq` pulse, 2+8+9·16=154 cycles after the `rx` fall. Then `rx_data=8'hA5`, `rx_valid=1`, both error flags 0. Pulse `rd_ack` → `rx_valid=0` next cycle, `rx_data` still `A5`.
- Send `0x3C` then `0xC3` back-to-back with no `rd_ack` → two `rx_irq` pulses, `rx_data=8'hC3`, `overrun=1`. Pulse `clr_err` → `overrun=0`.
- Send the second byte with `rd_ack` asserted in the stop-sample cycle → `rx_valid=1`, `overrun=0`, `rx_data` = second byte.
- Send `0x55` with the stop bit driven 0 → `frame_err=1`, no `rx_irq`, `rx_data` and `rx_valid` unchanged. Next frame `0x01` is received correctly.
- Cover two reset and glitch cases:
  - Hold `rx` low for 4 cycles only → back to IDLE, no flags, no irq.
  - Assert `reset=0` during data bit 4 of a frame → all outputs 0 next cycle. The following full frame `0x7E` is received correctly.

Source files
------------

// File: rtl/uart_rx_clic.sv
// rtl/uart_rx_clic.sv - 8N1 UART receiver with holding register, sticky error flags and CLIC irq pulse
module uart_rx_clic #(
  parameter int ClkFreq  = 20_000_000,
  parameter int BaudRate = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_irq,
  output logic       overrun,
  output logic       frame_err
);

  localparam int ClksPerBit = ClkFreq / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            irq_q, irq_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      irq_q     <= irq_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q & ~rd_ack;
    irq_d   = 1'b0;
    ovr_d   = ovr_q & ~clr_err;
    ferr_d  = ferr_q & ~clr_err;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // The cycle that sees the falling edge is the first half-bit clock.
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = CntW'(1);
        end
      end
      START: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          sh_d  = {rx_s_q, sh_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            irq_d   = 1'b1;
            if (valid_q && !rd_ack) ovr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_irq    = irq_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_clic.sv
// tb/tb_uart_rx_clic.sv - scoreboard bench for uart_rx_clic at 16 clocks per bit
module tb_uart_rx_clic;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_irq;
  logic       overrun;
  logic       frame_err;

  uart_rx_clic #(.ClkFreq(1600), .BaudRate(100)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_ack(rd_ack), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_irq(rx_irq),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_data_q[$];
  int         exp_time_q[$];
  logic [7:0] m_data;
  int         m_time;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each good frame's irq is due 154 cycles after the rx fall.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic ack_at_stop);
    if (stop_bit) begin
      exp_data_q.push_back(d);
      exp_time_q.push_back(cyc + 154);
    end
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = stop_bit;
    tick(9);
    rd_ack = ack_at_stop;
    tick(1);
    rd_ack = 1'b0;
    rx = 1'b1;
    tick(6);
  endtask

  always @(negedge clk) begin
    if (rx_irq === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_irq: got irq with rx_data=%0h at cycle %0d, required none", rx_data, cyc);
      end else begin
        m_data = exp_data_q.pop_front();
        m_time = exp_time_q.pop_front();
        check("irq_data", rx_data, m_data);
        check("irq_latency", cyc, m_time);
        check("irq_valid", rx_valid, 1);
      end
    end
  end

  initial begin
    reset = 1'b0;
    rx = 1'b1;
    tick(3);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_irq", rx_irq, 0);
    check("rst_ovr", overrun, 0);
    check("rst_ferr", frame_err, 0);
    reset = 1'b1;
    tick(200);

    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1);
    check("a5_ovr", overrun, 0);
    check("a5_ferr", frame_err, 0);
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    check("ack_valid", rx_valid, 0);
    check("ack_data", rx_data, 8'hA5);

    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(2);
    check("b2b_data", rx_data, 8'hC3);
    check("b2b_ovr", overrun, 1);
    check("b2b_valid", rx_valid, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_ovr", overrun, 0);

    send_frame(8'h96, 1'b1, 1'b1);
    tick(2);
    check("ackstop_valid", rx_valid, 1);
    check("ackstop_ovr", overrun, 0);
    check("ackstop_data", rx_data, 8'h96);

    send_frame(8'h55, 1'b0, 1'b0);
    tick(20);
    check("ferr_flag", frame_err, 1);
    check("ferr_data", rx_data, 8'h96);
    check("ferr_valid", rx_valid, 1);

    send_frame(8'h01, 1'b1, 1'b0);
    tick(2);
    check("after_ferr_data", rx_data, 8'h01);
    check("after_ferr_ovr", overrun, 1);
    check("after_ferr_ferr", frame_err, 1);
    clr_err = 1'b1;
    rd_ack = 1'b1;
    tick(1);
    clr_err = 1'b0;
    rd_ack = 1'b0;
    check("clr_both_ovr", overrun, 0);
    check("clr_both_ferr", frame_err, 0);
    check("clr_valid", rx_valid, 0);

    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);
    check("glitch_data", rx_data, 8'h01);

    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b1 : (i == 0 ? 1'b0 : 1'b1);
      tick(16);
    end
    rx = 1'b1;
    tick(8);
    reset = 1'b0;
    tick(1);
    check("midrst_data", rx_data, 0);
    check("midrst_valid", rx_valid, 0);
    check("midrst_irq", rx_irq, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_ferr", frame_err, 0);
    rx = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(50);
    check("postrst_valid", rx_valid, 0);

    send_frame(8'h7E, 1'b1, 1'b0);
    tick(2);
    check("7e_data", rx_data, 8'h7E);
    check("7e_valid", rx_valid, 1);
    check("7e_ovr", overrun, 0);
    check("7e_ferr", frame_err, 0);

    for (int i = 0; i < 100 && exp_data_q.size() > 0; i++) tick(1);
    check("queue_drained", exp_data_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
